// File: rtl/beam_scheduler.sv
// beam_scheduler: sequences ball raster, plate line and playfield border
// onto the X/Y DAC, holding each point for DWELL cycles. Object coordinates
// are latched once per frame so a frame never mixes old and new positions.
module beam_scheduler #(
    parameter int unsigned DWELL       = 4,
    parameter int unsigned BALL_R      = 2,
    parameter logic [7:0]  PADDLE_X    = 8'd4,
    parameter logic [7:0]  PADDLE_HALF = 8'd16,
    parameter logic [7:0]  BORDER_STEP = 8'd8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] x_b,
    input  logic [7:0] y_b,
    input  logic [7:0] y_p_mid,
    output logic [7:0] x,
    output logic [7:0] y,
    output logic       blank,
    output logic [1:0] phase,
    output logic       frame_start
);

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_BALL   = 2'd1,
        PH_PADDLE = 2'd2,
        PH_BORDER = 2'd3
    } phase_t;

    localparam int unsigned STEP  = int'(BORDER_STEP);
    localparam int unsigned SHIFT = $clog2(STEP);
    localparam int unsigned N_PTS = 256 / STEP;

    localparam logic [9:0] BALL_LAST = 10'(2 * BALL_R);
    localparam logic [3:0] ROW_LAST  = 4'(2 * BALL_R);
    localparam logic [9:0] PAD_LAST  = 10'(2 * int'(PADDLE_HALF));
    localparam logic [9:0] BRD_LAST  = 10'(N_PTS - 1);
    localparam logic [7:0] DW_LAST   = 8'(DWELL - 1);

    localparam logic signed [9:0] R_S  = 10'(BALL_R);
    localparam logic signed [9:0] PH_S = $signed({2'b00, PADDLE_HALF});

    // a: inner point index (ball dx, plate k, border k); b: ball row / border edge
    phase_t     phase_q, phase_d;
    logic [9:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [7:0] dwell_q, dwell_d;
    logic [7:0] xb_q, xb_d, yb_q, yb_d, yp_q, yp_d;
    logic [7:0] x_q, x_d, y_q, y_d;
    logic       blank_q, blank_d;
    logic       fs_q, fs_d;
    logic       start;

    logic signed [9:0] cx, cy;
    logic [9:0]        ks;

    function automatic logic [7:0] clamp8(input logic signed [9:0] v);
        if (v < 0)
            return '0;
        else if (v > 10'sd255)
            return '1;
        else
            return v[7:0];
    endfunction

    // Sequencing: dwell counting, point/phase advance, frame latch at boundaries
    always_comb begin
        phase_d = phase_q;
        a_d     = a_q;
        b_d     = b_q;
        dwell_d = dwell_q;
        xb_d    = xb_q;
        yb_d    = yb_q;
        yp_d    = yp_q;
        fs_d    = 1'b0;
        start   = 1'b0;
        if (phase_q == PH_IDLE) begin
            start = en;
        end else if (dwell_q != DW_LAST) begin
            dwell_d = dwell_q + 8'd1;
        end else begin
            dwell_d = '0;
            case (phase_q)
                PH_BALL: begin
                    if (a_q == BALL_LAST) begin
                        a_d = '0;
                        if (b_q == ROW_LAST) begin
                            b_d     = '0;
                            phase_d = PH_PADDLE;
                        end else begin
                            b_d = b_q + 4'd1;
                        end
                    end else begin
                        a_d = a_q + 10'd1;
                    end
                end
                PH_PADDLE: begin
                    if (a_q == PAD_LAST) begin
                        a_d     = '0;
                        phase_d = PH_BORDER;
                    end else begin
                        a_d = a_q + 10'd1;
                    end
                end
                PH_BORDER: begin
                    if (a_q == BRD_LAST) begin
                        a_d = '0;
                        if (b_q == 4'd3) begin
                            b_d     = '0;
                            phase_d = PH_IDLE;
                            start   = en;
                        end else begin
                            b_d = b_q + 4'd1;
                        end
                    end else begin
                        a_d = a_q + 10'd1;
                    end
                end
                default: ;
            endcase
        end
        if (start) begin
            phase_d = PH_BALL;
            a_d     = '0;
            b_d     = '0;
            dwell_d = '0;
            xb_d    = x_b;
            yb_d    = y_b;
            yp_d    = y_p_mid;
            fs_d    = 1'b1;
        end
    end

    // Next point coordinates, derived from next state so outputs stay registered
    always_comb begin
        cx = '0;
        cy = '0;
        ks = a_d << SHIFT;
        case (phase_d)
            PH_BALL: begin
                cx = $signed({2'b00, xb_d}) + $signed(a_d) - R_S;
                cy = $signed({2'b00, yb_d}) + $signed({6'd0, b_d}) - R_S;
            end
            PH_PADDLE: begin
                cx = $signed({2'b00, PADDLE_X});
                cy = $signed({2'b00, yp_d}) - PH_S + $signed(a_d);
            end
            PH_BORDER: begin
                case (b_d[1:0])
                    2'd0: begin cx = $signed(ks);              cy = '0;                     end
                    2'd1: begin cx = 10'sd255;                 cy = $signed(ks);            end
                    2'd2: begin cx = 10'sd255 - $signed(ks);   cy = 10'sd255;               end
                    default: begin cx = '0;                    cy = 10'sd255 - $signed(ks); end
                endcase
            end
            default: ;
        endcase
        x_d     = (phase_d == PH_IDLE) ? '0 : clamp8(cx);
        y_d     = (phase_d == PH_IDLE) ? '0 : clamp8(cy);
        blank_d = (phase_d == PH_IDLE) || (dwell_d == '0 && a_d == '0 && b_d == '0);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q <= PH_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            dwell_q <= '0;
            xb_q    <= '0;
            yb_q    <= '0;
            yp_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            blank_q <= 1'b1;
            fs_q    <= 1'b0;
        end else begin
            phase_q <= phase_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dwell_q <= dwell_d;
            xb_q    <= xb_d;
            yb_q    <= yb_d;
            yp_q    <= yp_d;
            x_q     <= x_d;
            y_q     <= y_d;
            blank_q <= blank_d;
            fs_q    <= fs_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign blank       = blank_q;
    assign phase       = phase_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_beam_scheduler.sv
// Testbench for beam_scheduler: a frame-level reference model expands each
// latched frame into per-cycle expected beam samples; a monitor compares them.
module tb_beam_scheduler;

    localparam int DW        = 4;
    localparam int R         = 2;
    localparam int PX        = 4;
    localparam int PH        = 16;
    localparam int S         = 8;
    localparam int N         = 256 / S;
    localparam int FRAME_LEN = ((2*R+1)*(2*R+1) + 2*PH + 1 + 4*N) * DW;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       en    = 1'b0;
    logic [7:0] x_b   = '0;
    logic [7:0] y_b   = '0;
    logic [7:0] y_p_mid = '0;
    logic [7:0] x, y;
    logic       blank, frame_start;
    logic [1:0] phase;

    beam_scheduler #(
        .DWELL(DW),
        .BALL_R(R),
        .PADDLE_X(8'(PX)),
        .PADDLE_HALF(8'(PH)),
        .BORDER_STEP(8'(S))
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .x_b(x_b),
        .y_b(y_b),
        .y_p_mid(y_p_mid),
        .x(x),
        .y(y),
        .blank(blank),
        .phase(phase),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int blank;
        int ph;
        int fs;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   busy     = 0;
    int   rem      = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic compare_out(input string tag, input exp_t e);
        chk({tag, ".x"}, int'(x), e.x);
        chk({tag, ".y"}, int'(y), e.y);
        chk({tag, ".blank"}, int'(blank), e.blank);
        chk({tag, ".phase"}, int'(phase), e.ph);
        chk({tag, ".frame_start"}, int'(frame_start), e.fs);
    endtask

    function automatic int clampi(input int v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    // One beam point held for DW cycles; blank only on the first cycle of a phase
    task automatic push_point(input int ph, input int idx, input int xv, input int yv);
        exp_t e;
        for (int d = 0; d < DW; d++) begin
            e.x     = clampi(xv);
            e.y     = clampi(yv);
            e.ph    = ph;
            e.blank = (idx == 0 && d == 0) ? 1 : 0;
            e.fs    = (ph == 1 && idx == 0 && d == 0) ? 1 : 0;
            q.push_back(e);
        end
    endtask

    task automatic push_frame(input int xb, input int yb, input int yp);
        int i;
        i = 0;
        for (int dy = -R; dy <= R; dy++)
            for (int dx = -R; dx <= R; dx++) begin
                push_point(1, i, xb + dx, yb + dy);
                i++;
            end
        for (int k = 0; k <= 2*PH; k++)
            push_point(2, k, PX, yp - PH + k);
        for (int k = 0; k < N; k++) push_point(3, k,         k*S,       0);
        for (int k = 0; k < N; k++) push_point(3, N + k,     255,       k*S);
        for (int k = 0; k < N; k++) push_point(3, 2*N + k,   255 - k*S, 255);
        for (int k = 0; k < N; k++) push_point(3, 3*N + k,   0,         255 - k*S);
    endtask

    // Reference model: frames are FRAME_LEN cycles; en matters only at a boundary
    always @(posedge clk) begin
        if (!reset) begin
            q.delete();
            busy = 0;
            rem  = 0;
        end else begin
            if (busy != 0) begin
                rem--;
                if (rem == 0) busy = 0;
            end
            if (busy == 0 && en) begin
                push_frame(int'(x_b), int'(y_b), int'(y_p_mid));
                busy = 1;
                rem  = FRAME_LEN;
            end
        end
    end

    // Monitor: pops one expected sample per active cycle, otherwise expects idle
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            e = '{0, 0, 1, 0, 0};
            compare_out("reset", e);
        end else if (q.size() > 0) begin
            e = q.pop_front();
            compare_out("frame", e);
        end else begin
            e = '{0, 0, 1, 0, 0};
            compare_out("idle", e);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check_reset_now(input string tag);
        #1;
        chk({tag, ".x"}, int'(x), 0);
        chk({tag, ".y"}, int'(y), 0);
        chk({tag, ".blank"}, int'(blank), 1);
        chk({tag, ".phase"}, int'(phase), 0);
        chk({tag, ".frame_start"}, int'(frame_start), 0);
    endtask

    initial begin
        #1 reset = 1'b0;
        check_reset_now("por");
        cyc(3);
        reset   = 1'b1;
        x_b     = 8'd100;
        y_b     = 8'd50;
        y_p_mid = 8'd128;
        en      = 1'b1;

        // frame coherence: change ball X while the plate is being drawn
        cyc(150);
        x_b = 8'd200;
        // clamping inputs, latched at the following frame boundary
        cyc(700);
        x_b     = 8'd1;
        y_b     = 8'd254;
        y_p_mid = 8'd5;

        // drop en during the ball phase; frame must still complete
        cyc(700);
        en = 1'b0;
        cyc(1000);
        chk("en_drop_phase", int'(phase), 0);
        chk("en_drop_blank", int'(blank), 1);
        cyc(20);
        x_b     = 8'd100;
        y_b     = 8'd50;
        y_p_mid = 8'd128;
        en      = 1'b1;
        cyc(1);
        chk("restart_fs", int'(frame_start), 1);
        chk("restart_phase", int'(phase), 1);

        // reset during border
        cyc(600);
        chk("pre_reset_phase", int'(phase), 3);
        reset = 1'b0;
        check_reset_now("async_reset");
        cyc(3);
        reset = 1'b1;

        for (int it = 0; it < 25; it++) begin
            cyc(int'($urandom_range(1, 500)));
            x_b     = 8'($urandom_range(0, 255));
            y_b     = 8'($urandom_range(0, 255));
            y_p_mid = 8'($urandom_range(0, 255));
            en      = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 9) == 0) begin
                reset = 1'b0;
                check_reset_now("rand_reset");
                cyc(2);
                reset = 1'b1;
            end
        end

        en = 1'b0;
        for (int i = 0; i < 2*FRAME_LEN; i++) begin
            if (q.size() == 0 && phase == 2'd0) break;
            cyc(1);
        end
        chk("drain_queue", q.size(), 0);
        chk("final_phase", int'(phase), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
